mac_vector_driver: RTL and testbench
====================================

# mac_vector_driver

Stream controller on the initiator side of the `part3_mac` valid_in/valid_out interface. It buffers one vector of signed (a, b) operand pairs from an upstream valid/ready source, clears the MAC accumulator, and streams the pairs into the MAC at one per cycle. It then counts the MAC's `valid_out` pulses, captures the final dot product and presents it on a downstream valid/ready port. It sits between the operand loader and the result sink, with the MAC instantiated alongside it.

## Interface
Parameters:
- `VEC_LEN`, default 8: pairs per vector; legal range 1–64.
- `CAPTURE_DELAY`, default 1: cycles between the final `mac_valid_out` pulse and sampling `mac_f`; legal range 0–3.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `s_valid`  in  1  upstream pair valid
- `s_ready`  out  1  upstream pair accepted this cycle when `s_valid && s_ready`
- `s_a`, `s_b`  in  10 each  signed operands
- `mac_a`, `mac_b`  out  10 each  operands to the MAC
- `mac_valid_in`  out  1  MAC operand strobe
- `mac_clr`  out  1  accumulator clear, ORed externally into the MAC reset
- `mac_f`  in  20  signed MAC result
- `mac_valid_out`  in  1  MAC result strobe
- `m_data`  out  20  captured signed dot product
- `m_valid`  out  1  result valid
- `m_ready`  in  1  downstream accept

## Operation
FSM states: LOAD → CLEAR → STREAM → DRAIN → CAPTURE → OUT → LOAD.

- **LOAD**
  - `s_ready` = 1.
  - Each handshake writes the pair to buffer[wr_cnt] and increments wr_cnt.
  - On the handshake that makes wr_cnt = VEC_LEN, go to CLEAR.
  - `s_valid` is ignored in every other state, and `s_ready` = 0 there.
- **CLEAR**
  - Registered `mac_clr` = 1 for exactly one cycle.
  - rd_cnt and rx_cnt are zeroed.
  - Go to STREAM.
- **STREAM**
  - Each cycle registers buffer[rd_cnt] onto `mac_a`/`mac_b`, sets `mac_valid_in` = 1, and increments rd_cnt.
  - After VEC_LEN issues, go to DRAIN.
- **DRAIN**
  - `mac_valid_in` = 0 and `mac_a`/`mac_b` hold their last values.
  - rx_cnt counts `mac_valid_out` pulses, starting from the first STREAM cycle.
  - When rx_cnt reaches VEC_LEN, go to CAPTURE.
- **CAPTURE**
  - Wait `CAPTURE_DELAY` cycles.
  - Latch `mac_f` into `m_data`.
  - Go to OUT.
- **OUT**
  - `m_valid` = 1, with `m_data` stable.
  - On `m_valid && m_ready`, clear wr_cnt and go to LOAD.

Arithmetic:
- No arithmetic is performed on data; the MAC result is passed through unchanged.
- Saturation values are 20'h7FFFF and 20'h80000.

Boundary conditions:
- `mac_valid_out` pulses arriving in LOAD, CLEAR or OUT are ignored and not counted.
- Extra pulses after rx_cnt reaches VEC_LEN are ignored.
- VEC_LEN = 1: STREAM lasts one cycle.
- `reset` in any state, including mid-STREAM:
  - next state LOAD;
  - buffer contents are don't-care;
  - all counters are 0.

## Timing
- Reset values:
  - `s_ready` = 1 (LOAD).
  - `mac_a`, `mac_b`, `mac_valid_in`, `mac_clr`, `m_data`, `m_valid` = 0.
- `mac_clr` is high in the cycle after the final load handshake.
- The first `mac_valid_in` is asserted the cycle after `mac_clr`.
- `mac_valid_in` is high for exactly VEC_LEN consecutive cycles, with no gaps.
- `m_valid` rises (CAPTURE_DELAY + 1) cycles after the cycle in which the VEC_LEN-th `mac_valid_out` is sampled.
- If `m_ready` is held high, `m_valid` lasts one cycle and `s_ready` is 1 the following cycle.
- Under backpressure, `m_valid` and `m_data` hold until accepted.
- All outputs are registered except `s_ready`, which is decoded from state.

## Configuration
- `MAC_DRV_SAT_FLAG_EN` defined:
  - Adds output port `m_sat` (1 bit, reset 0).
  - `m_sat` is latched with `m_data` and is 1 when the captured value equals 20'h7FFFF or 20'h80000.
  - It is valid while `m_valid` = 1.
- Not defined: the port and its logic are absent, and behaviour is otherwise identical.

## Test plan
- **Basic dot product** (VEC_LEN = 4): load (1,2), (3,4), (5,6), (7,8) → one `mac_clr` pulse, then four consecutive `mac_valid_in` cycles → `m_data` = 100, `m_valid` = 1.
- **Positive saturation**: load four pairs of (511,511) → `m_data` = 20'h7FFFF; `m_sat` = 1 with the macro.
- **Negative pairs and clear between vectors**: vector (−3,4) ×4 gives −48, then vector (2,2) ×4 gives 16 → the second result must not include the −48.
- **Upstream bubbles and downstream backpressure**: `s_valid` toggled every other cycle during LOAD; `m_ready` held 0 for 5 cycles → `m_data` stable, `m_valid` held, `s_ready` = 0 until accept.
- **Reset mid-operation**: `reset` asserted after 2 of 4 STREAM issues → next cycle `mac_valid_in` = 0, `m_valid` = 0, `s_ready` = 1; a fresh vector (1,1) ×4 → `m_data` = 4.
- **Stray strobes**: two extra `mac_valid_out` pulses injected during LOAD → ignored; the result is still correct.

Source files
------------

// File: rtl/mac_vector_driver.sv
// Initiator-side stream controller for the MAC: buffers one operand vector, clears and feeds the
// MAC, counts result strobes and hands the final dot product downstream. Optional MAC_DRV_SAT_FLAG_EN adds m_sat.
module mac_vector_driver #(
    parameter int VEC_LEN       = 8,
    parameter int CAPTURE_DELAY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [9:0]  s_a,
    input  logic [9:0]  s_b,
    output logic [9:0]  mac_a,
    output logic [9:0]  mac_b,
    output logic        mac_valid_in,
    output logic        mac_clr,
    input  logic [19:0] mac_f,
    input  logic        mac_valid_out,
    output logic [19:0] m_data,
    output logic        m_valid,
    input  logic        m_ready
`ifdef MAC_DRV_SAT_FLAG_EN
    ,
    output logic        m_sat
`endif
);

    localparam int CW    = $clog2(VEC_LEN + 1);
    localparam int AW    = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int DEPTH = 1 << AW;
    localparam logic [CW-1:0] LEN_C  = CW'(VEC_LEN);
    localparam logic [CW-1:0] LAST_C = CW'(VEC_LEN - 1);
    localparam logic [1:0]    DLY_LAST = 2'(CAPTURE_DELAY - 1);

    typedef enum logic [2:0] {
        S_LOAD    = 3'd0,
        S_CLEAR   = 3'd1,
        S_STREAM  = 3'd2,
        S_DRAIN   = 3'd3,
        S_CAPTURE = 3'd4,
        S_OUT     = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [9:0]    buf_a_q [DEPTH];
    logic [9:0]    buf_b_q [DEPTH];
    logic          buf_we_s;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [1:0]    dly_cnt_q, dly_cnt_d;
    logic          rx_hit_s;

    logic [9:0]  mac_a_q, mac_a_d;
    logic [9:0]  mac_b_q, mac_b_d;
    logic        mac_valid_in_q, mac_valid_in_d;
    logic        mac_clr_q, mac_clr_d;
    logic [19:0] m_data_q, m_data_d;
    logic        m_valid_q, m_valid_d;
`ifdef MAC_DRV_SAT_FLAG_EN
    logic        m_sat_q, m_sat_d;

    function automatic logic is_sat(input logic [19:0] v);
        return (v == 20'h7FFFF) || (v == 20'h80000);
    endfunction
`endif

    assign s_ready  = (state_q == S_LOAD);
    assign buf_we_s = (state_q == S_LOAD) && s_valid;
    // The final strobe may be the one arriving this very cycle.
    assign rx_hit_s = (rx_cnt_q == LEN_C) || (mac_valid_out && (rx_cnt_q == LAST_C));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD: begin
                if (s_valid && (wr_cnt_q == LAST_C)) state_d = S_CLEAR;
                else                                 state_d = S_LOAD;
            end
            S_CLEAR:  state_d = S_STREAM;
            S_STREAM: begin
                if (rd_cnt_q == LEN_C) state_d = S_DRAIN;
                else                   state_d = S_STREAM;
            end
            S_DRAIN: begin
                // With no capture delay the result is sampled straight out of DRAIN.
                if (rx_hit_s) state_d = (CAPTURE_DELAY == 0) ? S_OUT : S_CAPTURE;
                else          state_d = S_DRAIN;
            end
            S_CAPTURE: begin
                if (dly_cnt_q == DLY_LAST) state_d = S_OUT;
                else                       state_d = S_CAPTURE;
            end
            S_OUT: begin
                if (m_ready) state_d = S_LOAD;
                else         state_d = S_OUT;
            end
            default: state_d = S_LOAD;
        endcase
    end

    // Counter and registered-output next values, keyed on the upcoming state.
    always_comb begin
        wr_cnt_d       = wr_cnt_q;
        rd_cnt_d       = rd_cnt_q;
        rx_cnt_d       = rx_cnt_q;
        dly_cnt_d      = dly_cnt_q;
        mac_a_d        = mac_a_q;
        mac_b_d        = mac_b_q;
        mac_valid_in_d = 1'b0;
        mac_clr_d      = 1'b0;
        m_data_d       = m_data_q;
        m_valid_d      = (state_d == S_OUT);
`ifdef MAC_DRV_SAT_FLAG_EN
        m_sat_d        = m_sat_q;
`endif

        if (buf_we_s) wr_cnt_d = wr_cnt_q + 1'b1;
        else          wr_cnt_d = wr_cnt_d;

        if (state_d == S_CLEAR) begin
            mac_clr_d = 1'b1;
            rd_cnt_d  = '0;
            rx_cnt_d  = '0;
        end else if (state_d == S_STREAM) begin
            mac_a_d        = buf_a_q[rd_cnt_q[AW-1:0]];
            mac_b_d        = buf_b_q[rd_cnt_q[AW-1:0]];
            mac_valid_in_d = 1'b1;
            rd_cnt_d       = rd_cnt_q + 1'b1;
        end else begin
            rd_cnt_d = rd_cnt_d;
        end

        if (((state_q == S_STREAM) || (state_q == S_DRAIN)) && mac_valid_out && (rx_cnt_q != LEN_C))
            rx_cnt_d = rx_cnt_q + 1'b1;
        else
            rx_cnt_d = rx_cnt_d;

        if (state_d == S_CAPTURE) dly_cnt_d = (state_q == S_CAPTURE) ? dly_cnt_q + 2'd1 : 2'd0;
        else                      dly_cnt_d = dly_cnt_q;

        if ((state_d == S_OUT) && (state_q != S_OUT)) begin
            m_data_d = mac_f;
`ifdef MAC_DRV_SAT_FLAG_EN
            m_sat_d  = is_sat(mac_f);
`endif
        end else begin
            m_data_d = m_data_d;
        end

        if ((state_q == S_OUT) && (state_d == S_LOAD)) wr_cnt_d = '0;
        else                                           wr_cnt_d = wr_cnt_d;
    end

    // Counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt_q       <= '0;
            rd_cnt_q       <= '0;
            rx_cnt_q       <= '0;
            dly_cnt_q      <= 2'd0;
            mac_a_q        <= 10'd0;
            mac_b_q        <= 10'd0;
            mac_valid_in_q <= 1'b0;
            mac_clr_q      <= 1'b0;
            m_data_q       <= 20'd0;
            m_valid_q      <= 1'b0;
`ifdef MAC_DRV_SAT_FLAG_EN
            m_sat_q        <= 1'b0;
`endif
        end else begin
            wr_cnt_q       <= wr_cnt_d;
            rd_cnt_q       <= rd_cnt_d;
            rx_cnt_q       <= rx_cnt_d;
            dly_cnt_q      <= dly_cnt_d;
            mac_a_q        <= mac_a_d;
            mac_b_q        <= mac_b_d;
            mac_valid_in_q <= mac_valid_in_d;
            mac_clr_q      <= mac_clr_d;
            m_data_q       <= m_data_d;
            m_valid_q      <= m_valid_d;
`ifdef MAC_DRV_SAT_FLAG_EN
            m_sat_q        <= m_sat_d;
`endif
        end
    end

    // Operand buffer; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (buf_we_s) begin
            buf_a_q[wr_cnt_q[AW-1:0]] <= s_a;
            buf_b_q[wr_cnt_q[AW-1:0]] <= s_b;
        end else begin
            buf_a_q[wr_cnt_q[AW-1:0]] <= buf_a_q[wr_cnt_q[AW-1:0]];
            buf_b_q[wr_cnt_q[AW-1:0]] <= buf_b_q[wr_cnt_q[AW-1:0]];
        end
    end

    assign mac_a        = mac_a_q;
    assign mac_b        = mac_b_q;
    assign mac_valid_in = mac_valid_in_q;
    assign mac_clr      = mac_clr_q;
    assign m_data       = m_data_q;
    assign m_valid      = m_valid_q;
`ifdef MAC_DRV_SAT_FLAG_EN
    assign m_sat        = m_sat_q;
`endif

endmodule

// File: tb/tb_mac_vector_driver.sv
// Self-checking bench for mac_vector_driver with a behavioural saturating MAC alongside it.
module tb_mac_vector_driver;

    localparam int N = 4;
    localparam int D = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic        s_ready;
    logic [9:0]  s_a, s_b;
    logic [9:0]  mac_a, mac_b;
    logic        mac_valid_in, mac_clr;
    logic [19:0] mac_f;
    logic        mac_valid_out;
    logic [19:0] m_data;
    logic        m_valid;
    logic        m_ready;
`ifdef MAC_DRV_SAT_FLAG_EN
    logic        m_sat;
`endif

    int checks = 0;
    int errors = 0;
    int va_g [N];
    int vb_g [N];

    mac_vector_driver #(.VEC_LEN(N), .CAPTURE_DELAY(D)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .mac_a(mac_a), .mac_b(mac_b), .mac_valid_in(mac_valid_in), .mac_clr(mac_clr),
        .mac_f(mac_f), .mac_valid_out(mac_valid_out),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
`ifdef MAC_DRV_SAT_FLAG_EN
        , .m_sat(m_sat)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural MAC: one-cycle latency, saturating 20-bit accumulator.
    function automatic logic [19:0] sat20(input int v);
        if (v > 524287)  return 20'h7FFFF;
        if (v < -524288) return 20'h80000;
        return 20'(v);
    endfunction

    logic signed [19:0] acc_q;
    logic               vout_q;
    logic               stray;
    logic [19:0]        mac_next;
    assign mac_next = sat20(int'(acc_q) + int'($signed(mac_a)) * int'($signed(mac_b)));

    always @(posedge clk) begin
        if (reset || mac_clr) begin
            acc_q  <= 20'sd0;
            vout_q <= 1'b0;
        end else if (mac_valid_in) begin
            acc_q  <= mac_next;
            vout_q <= 1'b1;
        end else begin
            vout_q <= 1'b0;
        end
    end
    assign mac_f         = acc_q;
    assign mac_valid_out = vout_q | stray;

    // Reference: dot product of the vector, clamped to 20-bit signed after every term.
    function automatic int ref_dot();
        int acc = 0;
        for (int i = 0; i < N; i++) begin
            acc = acc + va_g[i] * vb_g[i];
            if (acc > 524287)  acc = 524287;
            if (acc < -524288) acc = -524288;
        end
        return acc;
    endfunction

    task automatic load_pairs(input bit bubbles, input bit stray_en);
        int idx = 0;
        int guard = 0;
        while (idx < N && guard < 200) begin
            @(negedge clk);
            guard++;
            stray   = stray_en && (guard == 1 || guard == 3);
            s_valid = bubbles ? (guard % 2 == 0) : 1'b1;
            s_a     = 10'(va_g[idx]);
            s_b     = 10'(vb_g[idx]);
            if (s_valid && s_ready) idx++;
        end
        checks++;
        if (idx != N) begin
            errors++;
            $display("FAIL load_handshakes: got %0d handshakes, want %0d", idx, N);
        end
    endtask

    task automatic run_vector(input string name, input bit bubbles, input bit stray_en, input int bp);
        int exp_v = ref_dot();
        int cyc = 0, clr_cnt = 0, clr_cyc = -1, vin_cnt = 0, vin_first = -1, vin_last = -1;
        int op_bad = 0, srdy_bad = 0, hold_bad = 0, mv_cyc = -1;
        m_ready = (bp == 0);
        load_pairs(bubbles, stray_en);
        while (cyc < 100 && mv_cyc < 0) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin s_valid = 1'b0; stray = 1'b0; end
            if (s_ready) srdy_bad++;
            if (mac_clr) begin clr_cnt++; clr_cyc = cyc; end
            if (mac_valid_in) begin
                if (vin_first < 0) vin_first = cyc;
                vin_last = cyc;
                if (vin_cnt < N && (mac_a !== 10'(va_g[vin_cnt]) || mac_b !== 10'(vb_g[vin_cnt]))) op_bad++;
                vin_cnt++;
            end
            if (m_valid) mv_cyc = cyc;
        end
        checks++;
        if (mv_cyc < 0) begin
            errors++;
            $display("FAIL %s_timeout: m_valid never rose within %0d cycles", name, cyc);
            return;
        end
        checks++;
        if (clr_cnt != 1 || clr_cyc != 1) begin
            errors++;
            $display("FAIL %s_clr: %0d pulses at cycle %0d, want 1 pulse at cycle 1", name, clr_cnt, clr_cyc);
        end
        checks++;
        if (vin_cnt != N || vin_first != 2 || vin_last != N + 1) begin
            errors++;
            $display("FAIL %s_valid_in: count %0d cycles %0d..%0d, want %0d cycles 2..%0d",
                     name, vin_cnt, vin_first, vin_last, N, N + 1);
        end
        checks++;
        if (op_bad != 0) begin
            errors++;
            $display("FAIL %s_operands: %0d wrong operand cycles, want 0", name, op_bad);
        end
        checks++;
        if (mv_cyc != N + D + 3) begin
            errors++;
            $display("FAIL %s_latency: m_valid at cycle %0d, want %0d", name, mv_cyc, N + D + 3);
        end
        checks++;
        if (m_data !== 20'(exp_v)) begin
            errors++;
            $display("FAIL %s_data: got %0d, want %0d", name, $signed(m_data), exp_v);
        end
`ifdef MAC_DRV_SAT_FLAG_EN
        checks++;
        if (m_sat !== (exp_v == 524287 || exp_v == -524288)) begin
            errors++;
            $display("FAIL %s_sat: got %0b, want %0b", name, m_sat, (exp_v == 524287 || exp_v == -524288));
        end
`endif
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            if (!m_valid || m_data !== 20'(exp_v) || s_ready) hold_bad++;
            if (s_ready) srdy_bad++;
        end
        m_ready = 1'b1;
        checks++;
        if (hold_bad != 0 || srdy_bad != 0) begin
            errors++;
            $display("FAIL %s_hold: %0d unstable hold cycles, %0d early s_ready cycles, want 0 and 0",
                     name, hold_bad, srdy_bad);
        end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_accept: m_valid=%0b s_ready=%0b, want 0 and 1", name, m_valid, s_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; s_valid = 1'b0; s_a = 10'd0; s_b = 10'd0; m_ready = 1'b1; stray = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || mac_valid_in !== 1'b0 || mac_clr !== 1'b0 || m_valid !== 1'b0 ||
            m_data !== 20'd0 || mac_a !== 10'd0 || mac_b !== 10'd0) begin
            errors++;
            $display("FAIL reset_state: s_ready=%0b vin=%0b clr=%0b m_valid=%0b m_data=%0h a=%0h b=%0h, want 1,0,0,0,0,0,0",
                     s_ready, mac_valid_in, mac_clr, m_valid, m_data, mac_a, mac_b);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        va_g = '{1, 3, 5, 7}; vb_g = '{2, 4, 6, 8};
        run_vector("basic", 1'b0, 1'b0, 0);
    endtask

    task automatic test_saturation();
        va_g = '{511, 511, 511, 511}; vb_g = '{511, 511, 511, 511};
        run_vector("pos_sat", 1'b0, 1'b0, 0);
        va_g = '{-512, -512, -512, -512}; vb_g = '{511, 511, 511, 511};
        run_vector("neg_sat", 1'b0, 1'b0, 0);
    endtask

    task automatic test_clear_between();
        va_g = '{-3, -3, -3, -3}; vb_g = '{4, 4, 4, 4};
        run_vector("neg_pairs", 1'b0, 1'b0, 0);
        va_g = '{2, 2, 2, 2}; vb_g = '{2, 2, 2, 2};
        run_vector("after_clear", 1'b0, 1'b0, 0);
    endtask

    task automatic test_bubbles_backpressure();
        va_g = '{9, -8, 7, -6}; vb_g = '{-5, 4, 3, 100};
        run_vector("bubbles_bp", 1'b1, 1'b0, 5);
    endtask

    task automatic test_stray_strobes();
        va_g = '{10, 20, 30, 40}; vb_g = '{1, 1, 1, 1};
        run_vector("stray", 1'b1, 1'b1, 0);
    endtask

    task automatic test_reset_mid_stream();
        int seen = 0;
        int guard = 0;
        va_g = '{100, 100, 100, 100}; vb_g = '{100, 100, 100, 100};
        load_pairs(1'b0, 1'b0);
        while (seen < 2 && guard < 50) begin
            @(negedge clk);
            guard++;
            s_valid = 1'b0;
            if (mac_valid_in) seen++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (seen != 2 || mac_valid_in !== 1'b0 || m_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: seen=%0d vin=%0b m_valid=%0b s_ready=%0b, want 2,0,0,1",
                     seen, mac_valid_in, m_valid, s_ready);
        end
        va_g = '{1, 1, 1, 1}; vb_g = '{1, 1, 1, 1};
        run_vector("after_reset", 1'b0, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < N; i++) begin
                va_g[i] = int'($urandom_range(1023, 0)) - 512;
                vb_g[i] = int'($urandom_range(1023, 0)) - 512;
            end
            run_vector("random", 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                       int'($urandom_range(3, 0)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_clear_between();
        test_bubbles_backpressure();
        test_stray_strobes();
        test_reset_mid_stream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
